lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter T_CLEAR, default 100000, busy cycles after the Clear command (0x01).
REQ-002 Parameter T_CHAR, default 2500, busy cycles after any other command or data write.
REQ-003 Parameter T_MIN_EN, default 10, minimum lcd_en high width, in cycles, for a transfer to be accepted.
REQ-004 Port clk, input, 1: single clock, 50 MHz, rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port lcd_rs, input, 1: 0 = command, 1 = data.
REQ-007 Port lcd_rw, input, 1: 0 = write, 1 = read.
REQ-008 Port lcd_en, input, 1: enable strobe from the LCD writer.
REQ-009 Port lcd_data, input, 8: bus byte from the writer.
REQ-010 Port lcd_data_out, output, 8: read-back byte, {busy, 3'b000, addr}, driven while lcd_rw=1 and lcd_en=1, else 0.
REQ-011 Port busy, output, 1: responder is executing the last accepted transfer.
REQ-012 Port addr, output, 4: DDRAM cursor address.
REQ-013 Port rd_addr, input, 4: display-buffer read index.
REQ-014 Port rd_char, output, 8: buffer[rd_addr], combinational.
REQ-015 Port cmd_valid, output, 1: one-cycle pulse when a write with rs=0 is accepted.
REQ-016 Port data_valid, output, 1: one-cycle pulse when a write with rs=1 is accepted.
REQ-017 Port last_byte, output, 8: byte of the last accepted write.
REQ-018 Port proto_err, output, 1: sticky flag for protocol violations; cleared only by reset.

Function
REQ-019 States SHALL be IDLE, STROBE, BUSY.
- IDLE to STROBE on lcd_en=1.
- STROBE to IDLE or BUSY on lcd_en falling edge.
- BUSY to IDLE when its counter expires.
REQ-020 In STROBE, rs, rw and data SHALL be re-captured every cycle; the values from the last high cycle are committed.
REQ-021 An en-high count SHALL saturate at T_MIN_EN; a falling edge with count < T_MIN_EN SHALL discard the transfer, set proto_err and return to IDLE.
REQ-022 A committed write SHALL pulse cmd_valid or data_valid in the cycle after the falling edge, update last_byte in that same cycle, and assert busy from that cycle.
REQ-023 Data write: buffer[addr] <= byte; addr <= addr+1, wrapping 15 to 0; busy for T_CHAR cycles.
REQ-024 Command 0x01: fill all 16 entries with 0x20, addr <= 0, busy for T_CLEAR cycles.
REQ-025 Command 0x02 or 0x03: addr <= 0, buffer unchanged, busy for T_CHAR cycles.
REQ-026 Command with bit7=1: addr <= byte[3:0], busy for T_CHAR cycles.
REQ-027 Any other command: no state change beyond busy for T_CHAR cycles; cmd_valid still pulses.
REQ-028 lcd_en rising while busy=1: proto_err set; the transfer is tracked but discarded at its falling edge; the busy countdown continues unaffected.
REQ-029 A committed transfer with lcd_rw=1: no buffer or addr change, no valid pulse, no busy.
REQ-030 busy SHALL deassert exactly T cycles after it asserts; a back-to-back strobe starting in the first non-busy cycle is legal.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE and zero all outputs: busy, addr, cmd_valid, data_valid, last_byte, proto_err, lcd_data_out.
REQ-032 Reset SHALL fill the buffer with 0x20 and clear all counters.
REQ-033 Reset asserted mid-strobe or mid-busy SHALL abort the transfer with no buffer update.

Structure
REQ-034 A shared package SHALL hold the state encoding, the command constants (CLEAR=0x01, HOME=0x02, SET_DDRAM mask=0x80) and the default timing values.
REQ-035 The 16x8 display buffer SHALL be a sub-module lcd_ddram: one write port with a clear-all input, one asynchronous read port.
REQ-036 The busy counter SHALL be 20 bits wide.

Verification
REQ-037 Reset, then write "A" (rs=1, 20-cycle en) -> data_valid pulse, rd_char[0]=0x41, addr=1, busy high for 2500 cycles.
REQ-038 Write 0x01 -> cmd_valid pulse, all 16 entries = 0x20, addr=0, busy high for 100000 cycles.
REQ-039 Write 0x85, then "X" -> buffer[5]=0x58, addr=6.
REQ-040 Write 17 characters from addr 0 -> wrap; buffer[0] = 17th character, addr=1.
REQ-041 5-cycle en pulse, or a strobe while busy -> no buffer change, proto_err=1 until reset.
REQ-042 Assert rst_n low during a clear's busy window -> busy=0 and addr=0 immediately, buffer all 0x20.

Source files
------------

// File: rtl/lcd_responder_pkg.sv
// Shared definitions for the LCD bus responder: state encoding, HD44780-style
// command constants and default timing.
package lcd_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    BUSY   = 2'd2
  } state_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CHAR_BLANK     = 8'h20;

  localparam int DEF_T_CLEAR  = 100000;
  localparam int DEF_T_CHAR   = 2500;
  localparam int DEF_T_MIN_EN = 10;
  localparam int BUSY_W       = 20;

endpackage

// File: rtl/lcd_responder_ddram.sv
// 16x8 display buffer: one synchronous write port with clear-to-blank,
// one asynchronous read port.
module lcd_ddram
  import lcd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic       clr_all,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= CHAR_BLANK;
    end else if (clr_all) begin
      for (int i = 0; i < 16; i++) mem[i] <= CHAR_BLANK;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_responder.sv
// Behavioural model of a character LCD controller seen from its bus side:
// validates enable strobes, executes writes and reports busy/read-back status.
//
//   state  | meaning
//   IDLE   | no strobe in progress, not busy
//   STROBE | lcd_en high, capturing rs/rw/data each cycle
//   BUSY   | executing the last accepted write, counter running
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int T_CLEAR  = DEF_T_CLEAR,
  parameter int T_CHAR   = DEF_T_CHAR,
  parameter int T_MIN_EN = DEF_T_MIN_EN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_data_out,
  output logic       busy,
  output logic [3:0] addr,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] last_byte,
  output logic       proto_err
);

  localparam int EN_W = $clog2(T_MIN_EN + 1);
  localparam logic [EN_W-1:0] EN_MIN = EN_W'(T_MIN_EN);

  state_t            state, state_nxt;
  logic [EN_W-1:0]   en_cnt;
  logic [BUSY_W-1:0] busy_cnt;
  logic              cap_rs, cap_rw;
  logic [7:0]        cap_data;
  logic              discard;

  logic start, fall, commit, too_short, wr;
  logic is_clear, is_home, is_ddram, ddram_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fall      = 1'b0;
    case (state)
      IDLE: begin
        if (lcd_en) begin
          state_nxt = STROBE;
          start     = 1'b1;
        end
      end
      STROBE: begin
        if (!lcd_en) begin
          fall = 1'b1;
          // A write commit always lands in BUSY; otherwise follow the counter.
          if ((!discard && en_cnt >= EN_MIN && !cap_rw) || busy_cnt > BUSY_W'(1))
            state_nxt = BUSY;
          else
            state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (lcd_en) begin
          state_nxt = STROBE;
          start     = 1'b1;
        end else if (busy_cnt <= BUSY_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit    = fall && !discard && (en_cnt >= EN_MIN);
    too_short = fall && (en_cnt < EN_MIN);
    wr        = commit && !cap_rw;
    is_clear  = wr && !cap_rs && (cap_data == CMD_CLEAR);
    is_home   = wr && !cap_rs && ((cap_data & 8'hFE) == CMD_HOME);
    is_ddram  = wr && !cap_rs && ((cap_data & CMD_DDRAM_MASK) != 8'h00);
    ddram_we  = wr && cap_rs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cnt   <= '0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= 8'h00;
      discard  <= 1'b0;
    end else begin
      if (lcd_en) begin
        cap_rs   <= lcd_rs;
        cap_rw   <= lcd_rw;
        cap_data <= lcd_data;
      end
      if (start) begin
        en_cnt  <= EN_W'(1);
        discard <= busy;
      end else if (state == STROBE && lcd_en && en_cnt < EN_MIN) begin
        en_cnt <= en_cnt + EN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt   <= '0;
      addr       <= 4'd0;
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      last_byte  <= 8'h00;
      proto_err  <= 1'b0;
    end else begin
      cmd_valid  <= wr && !cap_rs;
      data_valid <= wr && cap_rs;
      if (wr) last_byte <= cap_data;
      if ((start && busy) || too_short) proto_err <= 1'b1;

      if (wr)                    busy_cnt <= is_clear ? BUSY_W'(T_CLEAR) : BUSY_W'(T_CHAR);
      else if (busy_cnt != '0)   busy_cnt <= busy_cnt - BUSY_W'(1);

      if (ddram_we)                 addr <= addr + 4'd1;
      else if (is_clear || is_home) addr <= 4'd0;
      else if (is_ddram)            addr <= cap_data[3:0];
    end
  end

  assign busy         = (busy_cnt != '0);
  assign lcd_data_out = (lcd_rw && lcd_en) ? {busy, 3'b000, addr} : 8'h00;

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (ddram_we),
    .clr_all (is_clear),
    .waddr   (addr),
    .wdata   (cap_data),
    .raddr   (rd_addr),
    .rdata   (rd_char)
  );

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder with shortened busy times.
module tb_lcd_responder;

  localparam int TCL  = 400;
  localparam int TCH  = 30;
  localparam int TMIN = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic [7:0] lcd_data_out;
  logic       busy;
  logic [3:0] addr;
  logic [3:0] rd_addr;
  logic [7:0] rd_char;
  logic       cmd_valid, data_valid;
  logic [7:0] last_byte;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  lcd_responder #(.T_CLEAR(TCL), .T_CHAR(TCH), .T_MIN_EN(TMIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_data     (lcd_data),
    .lcd_data_out (lcd_data_out),
    .busy         (busy),
    .addr         (addr),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .cmd_valid    (cmd_valid),
    .data_valid   (data_valid),
    .last_byte    (last_byte),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int idx);
    rd_addr = 4'(idx);
    #1;
  endtask

  // Called at a negedge; leaves lcd_en low at a negedge with junk on the bus.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int len);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = d;
    lcd_en   = 1'b1;
    repeat (len) @(negedge clk);
    lcd_en   = 1'b0;
    lcd_rs   = ~rs;
    lcd_data = 8'hFF;
  endtask

  // Called at the first busy negedge; returns at the first non-busy negedge.
  task automatic wait_busy(input int t, input string tag);
    int n = 0;
    while (busy && n < t + 20) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, t);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input int t, input string tag);
    strobe(rs, 1'b0, d, 20);
    @(negedge clk);
    check({tag, "_cmd_valid"}, cmd_valid, !rs);
    check({tag, "_data_valid"}, data_valid, rs);
    check({tag, "_last_byte"}, last_byte, d);
    wait_busy(t, {tag, "_busy_len"});
  endtask

  initial begin
    int n;
    logic saw;
    rst_n = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0; lcd_data = 8'h00; rd_addr = 4'd0;
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_proto", proto_err, 0);
    check("rst_last", last_byte, 0);
    check("rst_valid", {cmd_valid, data_valid}, 0);
    check("rst_dout", lcd_data_out, 0);
    rd(7); check("rst_buf7", rd_char, 8'h20);

    // Data write 'A'
    strobe(1'b1, 1'b0, 8'h41, 20);
    @(negedge clk);
    check("A_data_valid", data_valid, 1);
    check("A_cmd_valid", cmd_valid, 0);
    check("A_last", last_byte, 8'h41);
    rd(0); check("A_buf0", rd_char, 8'h41);
    check("A_addr", addr, 1);
    @(negedge clk);
    check("A_pulse_width", data_valid, 0);
    wait_busy(TCH - 1, "A_busy_len");

    // Read strobe in the first non-busy cycle: legal, returns status
    lcd_rw = 1'b1; lcd_rs = 1'b0; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_dout", lcd_data_out, 8'h01);
    repeat (9) @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
    check("rd_no_valid", {cmd_valid, data_valid}, 0);
    check("rd_no_busy", busy, 0);
    check("rd_proto", proto_err, 0);
    check("rd_addr", addr, 1);
    lcd_rw = 1'b0;

    // Clear
    do_write(1'b0, 8'h01, TCL, "clr");
    check("clr_addr", addr, 0);
    for (int i = 0; i < 16; i++) begin
      rd(i); check("clr_buf", rd_char, 8'h20);
    end

    // Set DDRAM address then write 'X'
    do_write(1'b0, 8'h85, TCH, "ddram");
    check("ddram_addr", addr, 5);
    do_write(1'b1, 8'h58, TCH, "X");
    rd(5); check("X_buf5", rd_char, 8'h58);
    check("X_addr", addr, 6);

    // Home keeps buffer; other command changes nothing
    do_write(1'b0, 8'h03, TCH, "home");
    check("home_addr", addr, 0);
    rd(5); check("home_buf5", rd_char, 8'h58);
    do_write(1'b0, 8'h0C, TCH, "other");
    check("other_addr", addr, 0);

    // 17 characters wrap
    for (int i = 0; i < 17; i++) do_write(1'b1, 8'(97 + i), TCH, "wrap");
    rd(0); check("wrap_buf0", rd_char, 8'h71);
    rd(1); check("wrap_buf1", rd_char, 8'h62);
    rd(15); check("wrap_buf15", rd_char, 8'h70);
    check("wrap_addr", addr, 1);

    // Short enable pulse is discarded
    strobe(1'b1, 1'b0, 8'h55, 5);
    @(negedge clk);
    check("short_valid", {cmd_valid, data_valid}, 0);
    check("short_proto", proto_err, 1);
    check("short_busy", busy, 0);
    rd(1); check("short_buf1", rd_char, 8'h62);
    check("short_addr", addr, 1);
    check("short_last", last_byte, 8'h71);

    // Reset clears proto_err; then strobe during busy
    rst_n = 1'b0;
    #2;
    check("rst2_proto", proto_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1'b1, 1'b0, 8'h41, 20);
    @(negedge clk);
    check("B_data_valid", data_valid, 1);
    n = 1; saw = 1'b0;
    lcd_rs = 1'b1; lcd_data = 8'h5A; lcd_en = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy) n++;
      saw = saw | cmd_valid | data_valid;
    end
    lcd_en = 1'b0;
    while (busy && n < TCH + 20) begin
      @(negedge clk);
      if (busy) n++;
      saw = saw | cmd_valid | data_valid;
    end
    check("busy_strobe_len", n, TCH);
    check("busy_strobe_valid", saw, 0);
    check("busy_strobe_proto", proto_err, 1);
    rd(1); check("busy_strobe_buf1", rd_char, 8'h20);
    check("busy_strobe_addr", addr, 1);
    check("busy_strobe_last", last_byte, 8'h41);
    repeat (10) @(negedge clk);
    check("proto_sticky", proto_err, 1);

    // Reset mid-strobe aborts the write
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h4B; lcd_en = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0; lcd_en = 1'b0;
    #1;
    check("abort_addr", addr, 0);
    check("abort_proto", proto_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0); check("abort_buf0", rd_char, 8'h20);
    rd(1); check("abort_buf1", rd_char, 8'h20);
    check("abort_valid", data_valid, 0);

    // Reset during a clear's busy window
    do_write(1'b1, 8'h42, TCH, "pre");
    strobe(1'b0, 1'b0, 8'h01, 20);
    @(negedge clk);
    check("clr2_cmd_valid", cmd_valid, 1);
    repeat (50) @(negedge clk);
    check("clr2_busy_mid", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("clr2_rst_busy", busy, 0);
    check("clr2_rst_addr", addr, 0);
    for (int i = 0; i < 16; i++) begin
      rd(i); check("clr2_buf", rd_char, 8'h20);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
